// File: rtl/jb_period_meter.sv
// Period meter: counts clk cycles between successive event pulses, streams each
// period over valid/ready and keeps min/max/count statistics with sticky flags.
module jb_period_meter #(
  parameter int unsigned COUNT_WIDTH = 39,
  parameter int unsigned SCNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic                   event_in,
  input  logic [COUNT_WIDTH-1:0] timeout_value,
  input  logic                   clear_stats,
  output logic [COUNT_WIDTH-1:0] period_data,
  output logic                   period_valid,
  input  logic                   period_ready,
  output logic [COUNT_WIDTH-1:0] min_period,
  output logic [COUNT_WIDTH-1:0] max_period,
  output logic [SCNT_WIDTH-1:0]  sample_cnt,
  output logic                   timeout_flag,
  output logic                   overrun_flag
);

  typedef enum logic [1:0] {IDLE, ARMED, MEAS} state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SCNT_WIDTH-1:0]  SCNT_ONE = {{(SCNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state, state_n;
  logic [COUNT_WIDTH-1:0] cnt, cnt_n;
  logic                   capture, timeout_hit, load;
  logic [COUNT_WIDTH-1:0] min_base, max_base;
  logic [SCNT_WIDTH-1:0]  scnt_base;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE:  state_n = ARMED;
        ARMED: if (event_in) begin
          state_n = MEAS;
          cnt_n   = CNT_ONE;
        end
        MEAS: begin
          // An event on the timeout cycle takes priority and is captured.
          if (event_in) begin
            capture = 1'b1;
            cnt_n   = CNT_ONE;
          end else if (timeout_value != '0 && cnt == timeout_value) begin
            timeout_hit = 1'b1;
            cnt_n       = '0;
            state_n     = ARMED;
          end else if (cnt != '1) begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Clear is applied before any same-cycle capture.
  always_comb begin
    min_base  = clear_stats ? '1 : min_period;
    max_base  = clear_stats ? '0 : max_period;
    scnt_base = clear_stats ? '0 : sample_cnt;
    load      = capture && (!period_valid || period_ready);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      period_data  <= '0;
      period_valid <= 1'b0;
      min_period   <= '1;
      max_period   <= '0;
      sample_cnt   <= '0;
      timeout_flag <= 1'b0;
      overrun_flag <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        period_data  <= cnt;
        period_valid <= 1'b1;
      end else if (period_valid && period_ready) begin
        period_valid <= 1'b0;
      end
      min_period   <= (capture && cnt < min_base) ? cnt : min_base;
      max_period   <= (capture && cnt > max_base) ? cnt : max_base;
      sample_cnt   <= (capture && scnt_base != '1) ? scnt_base + SCNT_ONE : scnt_base;
      timeout_flag <= timeout_hit | (timeout_flag & ~clear_stats);
      overrun_flag <= (capture & ~load) | (overrun_flag & ~clear_stats);
    end
  end

endmodule

// File: doc/jb_period_meter.md
Name: jb_period_meter

Overview:
- Measures the spacing, in clk cycles, between successive single-cycle event pulses.
- Typical sources are terminal-count ticks from wrap-around counters or other pulse generators elsewhere in the design.
- Delivers each measured period over a valid/ready stream and keeps min/max/sample-count statistics plus sticky timeout and overrun flags for register readback.

Parameters:
- COUNT_WIDTH, 39, width of the period counter, period data, timeout and min/max values.
- SCNT_WIDTH, 32, width of the saturating sample counter.

Ports:
- clk  input  1  clock.
- resetn  input  1  reset, synchronous, active-low.
- enable  input  1  measurement enable; 0 abandons any measurement in progress.
- event_in  input  1  single-cycle event pulse, synchronous to clk.
- timeout_value  input  COUNT_WIDTH  cycles without an event before timeout; 0 disables timeout.
- clear_stats  input  1  single-cycle pulse; clears statistics and sticky flags.
- period_data  output  COUNT_WIDTH  measured period in cycles.
- period_valid  output  1  period_data holds an unconsumed sample.
- period_ready  input  1  consumer accepts period_data.
- min_period  output  COUNT_WIDTH  smallest captured period.
- max_period  output  COUNT_WIDTH  largest captured period.
- sample_cnt  output  SCNT_WIDTH  number of captures, saturating.
- timeout_flag  output  1  sticky timeout indicator.
- overrun_flag  output  1  sticky indicator that a sample was dropped.

Behaviour:

Reset (resetn=0):
- state=IDLE, cnt=0, period_data=0, period_valid=0.
- min_period=all ones, max_period=0, sample_cnt=0, timeout_flag=0, overrun_flag=0.
- Reset asserted mid-measurement discards everything.

States:
- IDLE: entered whenever enable=0, from any state, with cnt<=0. Moves to ARMED when enable=1.
- ARMED: waits for the first event. When event_in=1, go to MEAS with cnt<=1. No capture is made on this event.
- MEAS, cnt increments by 1 each cycle, saturating at all ones:
  - event_in=1: capture period=cnt, then cnt<=1 and stay in MEAS.
  - event_in=0, timeout_value!=0 and cnt==timeout_value: timeout_flag<=1, cnt<=0, go to ARMED, no capture.
  - Event and timeout condition in the same cycle: the event wins and is captured; timeout_flag is not set.

Period definition and latency:
- Events at cycles t0 and t1 give period = t1 - t0.
- Back-to-back events (every cycle) give period = 1.
- period_data and period_valid update on the clock edge ending the event cycle, i.e. visible one cycle after the event.

Output handshake:
- A transfer occurs when period_valid and period_ready are both 1.
- On capture, if period_valid=0 or period_ready=1: load period_data and set period_valid=1.
- On capture, if period_valid=1 and period_ready=0: the new sample is dropped, period_data holds, overrun_flag<=1.
- Transfer with no capture in the same cycle: period_valid<=0.
- period_data must not change while period_valid=1 and period_ready=0.

Statistics:
- Updated on every capture, including dropped samples.
- min_period<=min(min_period, period); max_period<=max(max_period, period).
- sample_cnt increments and saturates at all ones.
- Comparisons are unsigned, at full COUNT_WIDTH.

clear_stats:
- Sets min/max/sample_cnt to their reset values and clears timeout_flag and overrun_flag.
- Does not affect state, cnt, period_data or period_valid.
- Same cycle as a capture: the clear applies first, then the capture, giving min=max=period and sample_cnt=1.
- Same cycle as a timeout or overrun: that flag ends at 1.

enable:
- Deasserting enable mid-MEAS abandons the measurement with no capture.
- A pending output sample and the statistics are retained.
- Re-enabling returns to ARMED, so the first event after re-enable only arms.

Test Plan:
- Basic periods: enable=1, events at cycles 10, 15, 25, period_ready=1 -> first event no output. period_valid at 16 with data 5, at 26 with data 10. min=5, max=10, sample_cnt=2.
- Back-to-back events: events on cycles 100-103 -> three samples of 1, min_period=1.
- Backpressure: period_ready=0, events spaced 4, 7, 3 -> period_data stays 4, overrun_flag=1, max=7, min=3, sample_cnt=3. Then period_ready=1 for one cycle -> period_valid=0.
- Timeout: timeout_value=20, single event then silence -> timeout_flag=1 when cnt reaches 20, state back to ARMED. Next two events 6 apart -> sample 6. Event landing exactly on the timeout cycle -> captured, no timeout.
- clear_stats: issue it coincident with a capture of 9 -> min=max=9, sample_cnt=1, flags 0, period_valid unaffected.
- enable/reset mid-measure: drop enable 3 cycles after an event -> no sample, stats retained. resetn=0 mid-MEAS with period_valid=1 -> all outputs at reset values the next cycle.
